button_debounce: RTL and testbench
==================================

// Module: button_debounce
// PURPOSE
//  Front-end stage for the seven-segment digit counter. Turns the raw, bouncing, active-low push-button into a
//  clean pressed level plus single-cycle event pulses: press, release, long-press and auto-repeat.
//  The digit counter steps on press_pulse, and on repeat_pulse when fast-stepping is held.
// PARAMETERS
//  DEBOUNCE_CYCLES    5_000_000   stable cycles required to accept a level change (100 ms @ 50 MHz); >=2
//  LONG_PRESS_CYCLES  50_000_000  cycles from press_pulse to long_pulse (1 s); > DEBOUNCE_CYCLES
//  REPEAT_CYCLES      12_500_000  auto-repeat period after long_pulse; >=1
//  REPEAT_EN          1           1: generate repeat_pulse; 0: repeat_pulse tied 0
// PORTS
//  clk            in   1  system clock, single domain
//  rst_n          in   1  asynchronous, active-low reset
//  button         in   1  raw pushbutton, asynchronous, active-low (0 = pressed)
//  pressed        out  1  debounced level, 1 = held
//  press_pulse    out  1  1-cycle strobe on an accepted press
//  release_pulse  out  1  1-cycle strobe on an accepted release
//  long_pulse     out  1  1-cycle strobe, at most once per press
//  repeat_pulse   out  1  1-cycle strobe, periodic after long_pulse
// BEHAVIOUR
//  - Reset (async assert, sync release): state RELEASED, both synchroniser FFs = 1 (released), counters = 0,
//    all outputs 0. Reset mid-press never yields release_pulse. A button still held at reset release is
//    treated as a new press and needs a full debounce.
//  - Input path: 2-FF synchroniser, giving btn_s. All decisions use btn_s only.
//  - FSM states: RELEASED, PRESS_CHK, HELD, RELEASE_CHK.
//    RELEASED: btn_s==0 -> PRESS_CHK, deb_cnt=0.
//    PRESS_CHK: btn_s==1 -> RELEASED (bounce, no output).
//      deb_cnt reaches DEBOUNCE_CYCLES-1 -> HELD, press_pulse=1, pressed=1, hold_cnt=0, long_done=0.
//    HELD: hold_cnt increments each cycle.
//      hold_cnt==LONG_PRESS_CYCLES-1 with !long_done -> long_pulse, long_done=1, rep_cnt=0.
//      After that, each time rep_cnt==REPEAT_CYCLES-1 -> repeat_pulse, rep_cnt=0.
//      btn_s==1 -> RELEASE_CHK, deb_cnt=0.
//    RELEASE_CHK: hold_cnt and rep_cnt are frozen; no long or repeat pulses.
//      btn_s==0 -> HELD (bounce); counting resumes from the frozen values.
//      deb_cnt reaches DEBOUNCE_CYCLES-1 -> RELEASED, release_pulse=1, pressed=0.
//  - Latency: raw button edge to accepted pulse = DEBOUNCE_CYCLES+2 clk edges (2 of these are the synchroniser).
//    pressed changes in the same cycle as press_pulse / release_pulse.
//  - Exclusivity: at most one of the four pulses is high in any cycle.
//    The first repeat_pulse comes REPEAT_CYCLES after long_pulse, never in the same cycle.
//  - Widths: each counter is $clog2 of its limit. Counters never wrap: hold_cnt stops counting once long_done=1.
//  - All outputs are registered. No combinational path from button to any output.
// STRUCTURE
//  - btn_pkg: FSM state encodings (2-bit), default timing constants for 50 MHz.
//  - Sub-module sync_2ff (reset value parameter, here 1). The FSM and counters stay in button_debounce.
// TESTING (bench parameters: DEBOUNCE=8, LONG=40, REPEAT=10, REPEAT_EN=1; edges counted from stimulus edge)
//  1 Reset: rst_n=0 with button=0 -> all outputs 0 immediately.
//    Release rst_n, button held 0 -> press_pulse at edge 10, pressed=1.
//  2 Bounce: button 0 for 5 cycles, 1 for 1, then 0 -> no pulse during the glitch.
//    press_pulse exactly 10 edges after the final fall.
//  3 Hold: press, hold 75 cycles after press_pulse -> long_pulse at +40, repeat_pulse at +50, +60, +70.
//    No other pulses.
//  4 Release glitch: in HELD, button 1 for 5 cycles then 0 -> no release_pulse, pressed stays 1.
//    Stable 1 -> release_pulse 10 edges after the rise, pressed=0.
//  5 Reset mid-HELD: rst_n=0 during a repeat window -> outputs 0 asynchronously, no release_pulse.
//    After rst_n=1 with button still 0 -> new press_pulse at edge 10.
//  6 REPEAT_EN=0, hold 100 cycles -> exactly one long_pulse, repeat_pulse stays 0.

Source files
------------

// File: rtl/button_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce_pkg
// Description : Shared FSM state encoding and default 50 MHz timing constants
//               for the push-button debounce front end.
// Revision    : 1.0 - initial release
// ============================================================================
package button_debounce_pkg;

  // Debounce FSM states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_HELD        = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } btn_state_e;

  // Default timing at 50 MHz
  localparam int unsigned c_debounce_cycles_50mhz   = 5_000_000;   // 100 ms
  localparam int unsigned c_long_press_cycles_50mhz = 50_000_000;  // 1 s
  localparam int unsigned c_repeat_cycles_50mhz     = 12_500_000;  // 250 ms

endpackage : button_debounce_pkg
`default_nettype wire

// File: rtl/button_debounce_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for a single asynchronous bit, with a
//               parameterised reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  // Next values: shift the raw bit through the two stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops, forced to the idle level during reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : Debounces an active-low push-button and produces a clean
//               pressed level plus press / release / long-press / auto-repeat
//               single-cycle strobes. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = c_debounce_cycles_50mhz,
  parameter int unsigned LONG_PRESS_CYCLES = c_long_press_cycles_50mhz,
  parameter int unsigned REPEAT_CYCLES     = c_repeat_cycles_50mhz,
  parameter bit          REPEAT_EN         = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  // Counter widths; each counter only ever needs to hold limit-1
  localparam int c_deb_w  = $clog2(DEBOUNCE_CYCLES);
  localparam int c_hold_w = $clog2(LONG_PRESS_CYCLES);
  localparam int c_rep_w  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [c_deb_w-1:0]  c_deb_last  = c_deb_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(LONG_PRESS_CYCLES - 1);
  localparam logic [c_rep_w-1:0]  c_rep_last  = c_rep_w'(REPEAT_CYCLES - 1);

  logic btn_s;  // synchronised button, 0 = pressed

  btn_state_e          state_q,         state_d;
  logic [c_deb_w-1:0]  deb_cnt_q,       deb_cnt_d;
  logic [c_hold_w-1:0] hold_cnt_q,      hold_cnt_d;
  logic [c_rep_w-1:0]  rep_cnt_q,       rep_cnt_d;
  logic                long_done_q,     long_done_d;
  logic                pressed_q,       pressed_d;
  logic                press_pulse_q,   press_pulse_d;
  logic                release_pulse_q, release_pulse_d;
  logic                long_pulse_q,    long_pulse_d;
  logic                repeat_pulse_q,  repeat_pulse_d;
  logic [c_deb_w-1:0]  deb_cnt_inc;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (button),
    .q     (btn_s)
  );

  // The debounce counter "reaches" its limit when its incremented value hits
  // DEBOUNCE_CYCLES-1, so a level must be seen on DEBOUNCE_CYCLES edges.
  assign deb_cnt_inc = deb_cnt_q + 1'b1;

  // Next-state, counter and pulse logic
  always_comb begin
    state_d         = state_q;
    deb_cnt_d       = deb_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    rep_cnt_d       = rep_cnt_q;
    long_done_d     = long_done_q;
    pressed_d       = pressed_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    long_pulse_d    = 1'b0;
    repeat_pulse_d  = 1'b0;

    case (state_q)
      ST_RELEASED: begin
        if (!btn_s) begin
          state_d   = ST_PRESS_CHK;
          deb_cnt_d = '0;
        end
      end

      ST_PRESS_CHK: begin
        if (btn_s) begin
          state_d = ST_RELEASED;
        end else if (deb_cnt_inc == c_deb_last) begin
          state_d       = ST_HELD;
          press_pulse_d = 1'b1;
          pressed_d     = 1'b1;
          hold_cnt_d    = '0;
          rep_cnt_d     = '0;
          long_done_d   = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_inc;
        end
      end

      ST_HELD: begin
        // A release candidate takes priority; the timers pause on that edge
        if (btn_s) begin
          state_d   = ST_RELEASE_CHK;
          deb_cnt_d = '0;
        end else if (!long_done_q) begin
          if (hold_cnt_q == c_hold_last) begin
            long_pulse_d = 1'b1;
            long_done_d  = 1'b1;
            rep_cnt_d    = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end else if (REPEAT_EN) begin
          if (rep_cnt_q == c_rep_last) begin
            repeat_pulse_d = 1'b1;
            rep_cnt_d      = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
      end

      ST_RELEASE_CHK: begin
        // hold_cnt / rep_cnt stay frozen until the press is re-confirmed
        if (!btn_s) begin
          state_d = ST_HELD;
        end else if (deb_cnt_inc == c_deb_last) begin
          state_d         = ST_RELEASED;
          release_pulse_d = 1'b1;
          pressed_d       = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_inc;
        end
      end

      default: begin
        state_d = ST_RELEASED;
      end
    endcase
  end

  // State, counters and registered outputs; reset clears everything silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_RELEASED;
      deb_cnt_q       <= '0;
      hold_cnt_q      <= '0;
      rep_cnt_q       <= '0;
      long_done_q     <= 1'b0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_pulse_q    <= 1'b0;
      repeat_pulse_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      deb_cnt_q       <= deb_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      rep_cnt_q       <= rep_cnt_d;
      long_done_q     <= long_done_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_pulse_q    <= long_pulse_d;
      repeat_pulse_q  <= repeat_pulse_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign long_pulse    = long_pulse_q;
  assign repeat_pulse  = repeat_pulse_q;

endmodule : button_debounce
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debounce
// Description : Scoreboard bench for button_debounce. Two instances share the
//               stimulus: dut_a with auto-repeat, dut_b without.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debounce;

  localparam int c_press   = 0;
  localparam int c_release = 1;
  localparam int c_long    = 2;
  localparam int c_repeat  = 3;

  typedef struct {
    int cyc;
    int kind;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic button = 1'b1;

  logic a_pressed, a_press, a_release, a_long, a_repeat;
  logic b_pressed, b_press, b_release, b_long, b_repeat;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc equals the number of posedges so far
  always @(posedge clk) cyc <= cyc + 1;

  button_debounce #(
    .DEBOUNCE_CYCLES   (8),
    .LONG_PRESS_CYCLES (40),
    .REPEAT_CYCLES     (10),
    .REPEAT_EN         (1'b1)
  ) dut_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .button        (button),
    .pressed       (a_pressed),
    .press_pulse   (a_press),
    .release_pulse (a_release),
    .long_pulse    (a_long),
    .repeat_pulse  (a_repeat)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES   (8),
    .LONG_PRESS_CYCLES (40),
    .REPEAT_CYCLES     (10),
    .REPEAT_EN         (1'b0)
  ) dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .button        (button),
    .pressed       (b_pressed),
    .press_pulse   (b_press),
    .release_pulse (b_release),
    .long_pulse    (b_long),
    .repeat_pulse  (b_repeat)
  );

  task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int sel, input int at, input int kind);
    exp_t e;
    e.cyc  = at;
    e.kind = kind;
    if (sel == 0) q_a.push_back(e);
    else          q_b.push_back(e);
  endtask

  // Same event expected from both instances
  task automatic push_both(input int at, input int kind);
    push(0, at, kind);
    push(1, at, kind);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Compare one DUT's pulses this cycle against its expectation queue
  task automatic check_out(input int sel, input logic [3:0] p);
    exp_t e;
    bit   have;
    if (p[0] + p[1] + p[2] + p[3] > 1) begin
      n_tests++;
      n_fail++;
      $display("FAIL exclusive dut%0d: pulses %b at cyc %0d", sel, p, cyc);
    end
    for (int k = 0; k < 4; k++) begin
      if (p[k]) begin
        have = 1'b0;
        if (sel == 0 && q_a.size() > 0) begin
          e = q_a.pop_front();
          have = 1'b1;
        end else if (sel == 1 && q_b.size() > 0) begin
          e = q_b.pop_front();
          have = 1'b1;
        end
        n_tests++;
        if (!have) begin
          n_fail++;
          $display("FAIL unexpected dut%0d: kind %0d at cyc %0d, none expected", sel, k, cyc);
        end else if (e.cyc != cyc || e.kind != k) begin
          n_fail++;
          $display("FAIL event dut%0d: kind %0d at cyc %0d, expected kind %0d at cyc %0d",
                   sel, k, cyc, e.kind, e.cyc);
        end
      end
    end
  endtask

  // Monitor: sample pulses on the falling edge, away from the active edge
  always @(negedge clk) begin
    check_out(0, {a_repeat, a_long, a_release, a_press});
    check_out(1, {b_repeat, b_long, b_release, b_press});
  end

  initial begin : stim
    int p;
    int t;

    // 1: reset with button held, then release reset
    button = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_a", {a_pressed, a_press, a_release, a_long, a_repeat}, 5'b0);
    chk("reset_b", {b_pressed, b_press, b_release, b_long, b_repeat}, 5'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    p = cyc + 10;
    push_both(p, c_press);
    wait_until(p + 1);
    chk("t1_pressed_a", {4'b0, a_pressed}, 5'd1);
    chk("t1_pressed_b", {4'b0, b_pressed}, 5'd1);
    button = 1'b1;
    push_both(p + 11, c_release);
    wait_until(p + 12);
    chk("t1_released_a", {4'b0, a_pressed}, 5'd0);
    wait_until(p + 20);

    // 2: bounce on press; 3: hold 75 cycles with long and repeats
    t = cyc;
    button = 1'b0;
    wait_until(t + 5);
    button = 1'b1;
    wait_until(t + 6);
    button = 1'b0;
    p = cyc + 10;
    push_both(p, c_press);
    push_both(p + 40, c_long);
    push(0, p + 50, c_repeat);
    push(0, p + 60, c_repeat);
    push(0, p + 70, c_repeat);
    wait_until(p + 1);
    chk("t2_pressed_a", {4'b0, a_pressed}, 5'd1);
    wait_until(p + 75);
    button = 1'b1;
    push_both(p + 85, c_release);
    wait_until(p + 84);
    chk("t3_still_pressed_b", {4'b0, b_pressed}, 5'd1);
    wait_until(p + 86);
    chk("t3_released_a", {4'b0, a_pressed}, 5'd0);
    chk("t3_released_b", {4'b0, b_pressed}, 5'd0);
    wait_until(p + 95);

    // 4: release glitch while held, then a clean release
    button = 1'b0;
    p = cyc + 10;
    push_both(p, c_press);
    wait_until(p + 1);
    button = 1'b1;
    wait_until(p + 6);
    button = 1'b0;
    wait_until(p + 10);
    chk("t4_glitch_pressed_a", {4'b0, a_pressed}, 5'd1);
    chk("t4_glitch_pressed_b", {4'b0, b_pressed}, 5'd1);
    button = 1'b1;
    push_both(p + 20, c_release);
    wait_until(p + 19);
    chk("t4_before_release_a", {4'b0, a_pressed}, 5'd1);
    wait_until(p + 21);
    chk("t4_released_a", {4'b0, a_pressed}, 5'd0);
    wait_until(p + 30);

    // 5: reset while held, inside a repeat window
    button = 1'b0;
    p = cyc + 10;
    push_both(p, c_press);
    push_both(p + 40, c_long);
    push(0, p + 50, c_repeat);
    wait_until(p + 55);
    rst_n = 1'b0;
    #1;
    chk("t5_reset_a", {a_pressed, a_press, a_release, a_long, a_repeat}, 5'b0);
    chk("t5_reset_b", {b_pressed, b_press, b_release, b_long, b_repeat}, 5'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 6: button still held after reset -> new press, hold 100 cycles
    p = cyc + 10;
    push_both(p, c_press);
    push_both(p + 40, c_long);
    for (int r = 50; r <= 100; r += 10) push(0, p + r, c_repeat);
    wait_until(p + 1);
    chk("t6_pressed_b", {4'b0, b_pressed}, 5'd1);
    wait_until(p + 100);
    button = 1'b1;
    push_both(p + 110, c_release);
    wait_until(p + 111);
    chk("t6_released_b", {4'b0, b_pressed}, 5'd0);
    wait_until(p + 140);

    // Every expected event must have been consumed
    n_tests++;
    if (q_a.size() != 0) begin
      n_fail++;
      $display("FAIL missing_a: %0d events left, next kind %0d at cyc %0d",
               q_a.size(), q_a[0].kind, q_a[0].cyc);
    end
    n_tests++;
    if (q_b.size() != 0) begin
      n_fail++;
      $display("FAIL missing_b: %0d events left, next kind %0d at cyc %0d",
               q_b.size(), q_b[0].kind, q_b[0].cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_button_debounce
`default_nettype wire
